regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
Parametrised successor to the single-cycle register file, built for the multicycle/pipelined core.
- N read ports, each with same-cycle write-back bypass.
- One write-back port.
- Per-register pending-write scoreboard with a valid/ready issue handshake. Decode uses it to stall on RAW hazards against long-latency results (loads, mul/div).

Parameters:
DATA_W, 32, register width in bits
NUM_REGS, 32, number of architectural registers (power of two, >=2)
ADDR_W, $clog2(NUM_REGS), register index width (derived, not overridden)
NUM_RD, 2, number of read ports (1..4)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
rd_addr  in  NUM_RD*ADDR_W  read addresses, port p at [p*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  read data, port p at [p*DATA_W +: DATA_W]
rd_busy  out  NUM_RD  port p source has an outstanding write not yet written back
issue_valid  in  1  decode requests to mark issue_addr pending
issue_addr  in  ADDR_W  destination of the issued long-latency instruction
issue_ready  out  1  issue accepted this cycle when issue_valid && issue_ready
wb_valid  in  1  write-back strobe
wb_addr  in  ADDR_W  write-back destination
wb_data  in  DATA_W  write-back value
wb_err  out  1  registered one-cycle pulse: write-back to a non-pending register
outstanding  out  ADDR_W+1  registered count of pending registers

Behaviour:
- Register 0 (reset):
  - Reads as 0 on every port.
  - Writes to it are discarded.
  - Issues to it are always ready, never set pending, and never count.
- Reset (asynchronous, any time, including mid-operation):
  - All registers 0, all pending bits 0, wb_err 0, outstanding 0.
  - A write in flight at reset assertion is lost.
- Write:
  - On rising clock, wb_valid && wb_addr!=0 stores wb_data at wb_addr.
  - Clears pending[wb_addr].
- Read (combinational, zero latency):
  - rd_data[p] = wb_data if wb_valid && wb_addr==rd_addr[p] && rd_addr[p]!=0 (bypass).
  - Otherwise rd_data[p] = register[rd_addr[p]]; 0 if rd_addr[p]==0.
- rd_busy[p] = pending[rd_addr[p]] && !(wb_valid && wb_addr==rd_addr[p]).
  - A write-back in the same cycle un-busies the read.
- Issue handshake:
  - issue_ready = !pending[issue_addr] || (wb_valid && wb_addr==issue_addr).
  - issue_ready does not depend on issue_valid.
  - Accepted issue sets pending[issue_addr] on the next edge.
  - A WAW issue to an already-pending register waits until that register's write-back cycle.
- Simultaneous wb and accepted issue to the same address:
  - Write is performed and the register ends pending (issue wins).
  - wb_err follows the pre-edge pending state.
- wb_err:
  - Next cycle = wb_valid && wb_addr!=0 && !pending[wb_addr] (pre-edge).
  - The write is still performed.
- outstanding:
  - Popcount of the post-edge pending vector, updated every edge.
  - Never exceeds NUM_REGS-1.

Optional Feature:
REGFILE_RESET_INDEX_EN.
- Defined: reset loads register i with value i (zero-extended to DATA_W); register 0 stays 0. Used for bring-up and simulation visibility.
- Undefined: reset loads all registers with 0.
- Pending, wb_err and outstanding behaviour are identical in both builds.

Decomposition:
- Shared package cpu_pkg:
  - DATA_W, NUM_REGS and ADDR_W defaults.
  - Localparams REG_ZERO=0 and REG_RA=31 (JAL link target).
- One natural sub-module, regfile_read_port: per-port bypass mux plus busy logic, instantiated NUM_RD times in a generate loop.
- Scoreboard vector and popcount stay in the top module.

Test Plan:
- Reset async mid-cycle with 3 pending -> outstanding=0, all rd_data=0 (or =index with REGFILE_RESET_INDEX_EN), wb_err=0, without waiting for a clock edge.
- Write 0xDEADBEEF to r5 while rd_addr[0]=5 -> rd_data[0]=0xDEADBEEF in the same cycle; next cycle still 0xDEADBEEF with wb_valid=0.
- Write 0x1234 to r0, read r0 on both ports -> 0; issue r0 -> issue_ready=1, outstanding unchanged.
- Issue r8, next cycle rd_addr[1]=8 -> rd_busy[1]=1, outstanding=1; re-issue r8 -> issue_ready=0. Write back r8=0x55 -> rd_busy[1]=0 that cycle, issue_ready=1; next cycle outstanding=0.
- Write back r9 (never issued) -> r9 written, wb_err=1 for exactly one cycle after the edge.
- Same-cycle issue r12 and wb r12 with r12 pending -> r12=wb_data, r12 remains pending, outstanding unchanged, wb_err=0.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_pkg
// Purpose : Shared CPU constants: default register-file geometry and the
//           architectural register indices with fixed meaning.
// Ports   : none (package)
// Revision: 1.0  initial release
// ============================================================================
package cpu_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_ADDR_W   = $clog2(DEF_NUM_REGS);

    // Hard-wired zero register and the JAL link target.
    localparam int REG_ZERO = 0;
    localparam int REG_RA   = 31;

endpackage
`default_nettype wire

// File: rtl/regfile_read_port.sv
`default_nettype none
// ============================================================================
// Module  : regfile_read_port
// Purpose : One combinational register-file read port with same-cycle
//           write-back bypass and scoreboard busy indication.
// Ports   : rd_addr_i   - register index to read
//           regs_i      - flattened register contents, reg r at [r*DATA_W +: DATA_W]
//           pending_i   - scoreboard vector, one bit per register
//           wb_valid_i / wb_addr_i / wb_data_i - write-back happening this cycle
//           rd_data_o   - read value (0 for register 0)
//           rd_busy_o   - source still waits on an outstanding write-back
// Revision: 1.0  initial release
// ============================================================================
module regfile_read_port
    import cpu_pkg::*;
#(
    parameter  int DATA_W   = DEF_DATA_W,
    parameter  int NUM_REGS = DEF_NUM_REGS,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic [ADDR_W-1:0]          rd_addr_i,
    input  logic [NUM_REGS*DATA_W-1:0] regs_i,
    input  logic [NUM_REGS-1:0]        pending_i,
    input  logic                       wb_valid_i,
    input  logic [ADDR_W-1:0]          wb_addr_i,
    input  logic [DATA_W-1:0]          wb_data_i,
    output logic [DATA_W-1:0]          rd_data_o,
    output logic                       rd_busy_o
);

    logic w_wb_hit;

    assign w_wb_hit = wb_valid_i && (wb_addr_i == rd_addr_i);

    always_comb begin
        if (rd_addr_i == ADDR_W'(REG_ZERO)) begin
            rd_data_o = '0;
        end else if (w_wb_hit) begin
            rd_data_o = wb_data_i;
        end else begin
            rd_data_o = regs_i[rd_addr_i*DATA_W +: DATA_W];
        end
    end

    // A write-back landing this cycle satisfies the dependency already,
    // because its value is forwarded through the bypass above.
    assign rd_busy_o = pending_i[rd_addr_i] && !w_wb_hit;

endmodule
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module  : regfile_scoreboard
// Purpose : Multi-port register file with write-back bypass and a per-register
//           pending-write scoreboard used by decode to stall on RAW/WAW hazards
//           against long-latency results.
// Config  : REGFILE_RESET_INDEX_EN - when defined, reset loads register i with
//           value i (register 0 stays 0); otherwise all registers reset to 0.
// Ports   : clock_i, reset_i (async, active-high)
//           rd_addr_i / rd_data_o / rd_busy_o - NUM_RD packed read ports
//           issue_valid_i / issue_addr_i / issue_ready_o - mark dest pending
//           wb_valid_i / wb_addr_i / wb_data_i - write-back port
//           wb_err_o      - one-cycle pulse: write-back to non-pending register
//           outstanding_o - number of pending registers
// Revision: 1.0  initial release
// ============================================================================
module regfile_scoreboard
    import cpu_pkg::*;
#(
    parameter  int DATA_W   = DEF_DATA_W,
    parameter  int NUM_REGS = DEF_NUM_REGS,
    parameter  int NUM_RD   = 2,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    input  logic                     issue_valid_i,
    input  logic [ADDR_W-1:0]        issue_addr_i,
    output logic                     issue_ready_o,
    input  logic                     wb_valid_i,
    input  logic [ADDR_W-1:0]        wb_addr_i,
    input  logic [DATA_W-1:0]        wb_data_i,
    output logic                     wb_err_o,
    output logic [ADDR_W:0]          outstanding_o
);

    logic [DATA_W-1:0]          regs_q [NUM_REGS];
    logic [NUM_REGS*DATA_W-1:0] regs_flat;
    logic [NUM_REGS-1:0]        pending_q, pending_d;
    logic                       wb_err_q, wb_err_d;
    logic [ADDR_W:0]            outstanding_q, outstanding_d;
    logic                       wb_write;
    logic                       issue_accept;

    assign wb_write = wb_valid_i && (wb_addr_i != ADDR_W'(REG_ZERO));

    // A pending destination frees up in its own write-back cycle, so a WAW
    // issue can be accepted back-to-back with the retiring write.
    assign issue_ready_o = !pending_q[issue_addr_i]
                         || (wb_valid_i && (wb_addr_i == issue_addr_i));
    assign issue_accept  = issue_valid_i && issue_ready_o
                         && (issue_addr_i != ADDR_W'(REG_ZERO));

    always_comb begin
        pending_d = pending_q;
        if (wb_valid_i) begin
            pending_d[wb_addr_i] = 1'b0;
        end
        // Set after clear: an issue accepted alongside a write-back to the
        // same register leaves it pending for the new producer.
        if (issue_accept) begin
            pending_d[issue_addr_i] = 1'b1;
        end
        pending_d[REG_ZERO] = 1'b0;

        wb_err_d = wb_write && !pending_q[wb_addr_i];

        outstanding_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            outstanding_d = outstanding_d + {{ADDR_W{1'b0}}, pending_d[i]};
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            pending_q     <= '0;
            wb_err_q      <= 1'b0;
            outstanding_q <= '0;
        end else begin
            pending_q     <= pending_d;
            wb_err_q      <= wb_err_d;
            outstanding_q <= outstanding_d;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
`ifdef REGFILE_RESET_INDEX_EN
                regs_q[i] <= DATA_W'(i);
`else
                regs_q[i] <= '0;
`endif
            end
        end else if (wb_write) begin
            regs_q[wb_addr_i] <= wb_data_i;
        end
    end

    assign wb_err_o      = wb_err_q;
    assign outstanding_o = outstanding_q;

    generate
        for (genvar r = 0; r < NUM_REGS; r++) begin : g_flat
            assign regs_flat[r*DATA_W +: DATA_W] = regs_q[r];
        end

        for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
            regfile_read_port #(
                .DATA_W   (DATA_W),
                .NUM_REGS (NUM_REGS)
            ) u_rd (
                .rd_addr_i  (rd_addr_i[p*ADDR_W +: ADDR_W]),
                .regs_i     (regs_flat),
                .pending_i  (pending_q),
                .wb_valid_i (wb_valid_i),
                .wb_addr_i  (wb_addr_i),
                .wb_data_i  (wb_data_i),
                .rd_data_o  (rd_data_o[p*DATA_W +: DATA_W]),
                .rd_busy_o  (rd_busy_o[p])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module  : tb_regfile_scoreboard
// Purpose : Self-checking bench for regfile_scoreboard. Stimulus queues the
//           expected value of a chosen DUT output; a monitor drains the queue
//           on every falling clock edge and compares.
// Revision: 1.0  initial release
// ============================================================================
module tb_regfile_scoreboard;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    // Output selectors used by the scoreboard.
    localparam int S_RD0 = 0, S_RD1 = 1, S_BUSY0 = 2, S_BUSY1 = 3;
    localparam int S_IRDY = 4, S_WERR = 5, S_OUTS = 6;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } item_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [2*ADDR_W-1:0] rd_addr = '0;
    logic [2*DATA_W-1:0] rd_data;
    logic [1:0]          rd_busy;
    logic                issue_valid = 1'b0;
    logic [ADDR_W-1:0]   issue_addr = '0;
    logic                issue_ready;
    logic                wb_valid = 1'b0;
    logic [ADDR_W-1:0]   wb_addr = '0;
    logic [DATA_W-1:0]   wb_data = '0;
    logic                wb_err;
    logic [ADDR_W:0]     outstanding;

    item_t q [$];
    int    n_tests = 0;
    int    n_fail  = 0;

    regfile_scoreboard #(.DATA_W(DATA_W), .NUM_REGS(32), .NUM_RD(2)) dut (
        .clock_i       (clk),
        .reset_i       (rst),
        .rd_addr_i     (rd_addr),
        .rd_data_o     (rd_data),
        .rd_busy_o     (rd_busy),
        .issue_valid_i (issue_valid),
        .issue_addr_i  (issue_addr),
        .issue_ready_o (issue_ready),
        .wb_valid_i    (wb_valid),
        .wb_addr_i     (wb_addr),
        .wb_data_i     (wb_data),
        .wb_err_o      (wb_err),
        .outstanding_o (outstanding)
    );

    always #5 clk = ~clk;

    // Expected reset contents of register idx.
    function automatic logic [31:0] rst_val(input int idx);
`ifdef REGFILE_RESET_INDEX_EN
        return 32'(idx);
`else
        return 32'd0 + 32'(idx * 0);
`endif
    endfunction

    task automatic expect_v(input string name, input int sel, input logic [31:0] v);
        item_t it;
        it.name = name;
        it.sel  = sel;
        it.exp  = v;
        q.push_back(it);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every queued expectation against the live DUT output.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            item_t       it;
            logic [31:0] act;
            it = q.pop_front();
            case (it.sel)
                S_RD0:   act = rd_data[31:0];
                S_RD1:   act = rd_data[63:32];
                S_BUSY0: act = {31'd0, rd_busy[0]};
                S_BUSY1: act = {31'd0, rd_busy[1]};
                S_IRDY:  act = {31'd0, issue_ready};
                S_WERR:  act = {31'd0, wb_err};
                default: act = {26'd0, outstanding};
            endcase
            n_tests++;
            if (act !== it.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", it.name, act, it.exp);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset state
        cyc();
        rst = 1'b0;
        expect_v("reset_outstanding", S_OUTS, 32'd0);
        expect_v("reset_wb_err", S_WERR, 32'd0);
        expect_v("reset_rd0_r0", S_RD0, 32'd0);
        expect_v("reset_issue_ready", S_IRDY, 32'd1);

        // Bypass write to r5 (non-pending, so wb_err pulses afterwards)
        cyc();
        rd_addr[4:0] = 5'd5;
        wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
        expect_v("bypass_r5", S_RD0, 32'hDEADBEEF);
        expect_v("bypass_r5_busy", S_BUSY0, 32'd0);
        cyc();
        wb_valid = 1'b0;
        expect_v("stored_r5", S_RD0, 32'hDEADBEEF);
        expect_v("r5_wb_err", S_WERR, 32'd1);
        cyc();
        expect_v("r5_wb_err_clear", S_WERR, 32'd0);

        // r0 writes discarded, issue to r0 always ready and never counted
        rd_addr = {5'd0, 5'd0};
        wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234;
        issue_valid = 1'b1; issue_addr = 5'd0;
        expect_v("r0_bypass_p0", S_RD0, 32'd0);
        expect_v("r0_bypass_p1", S_RD1, 32'd0);
        expect_v("r0_issue_ready", S_IRDY, 32'd1);
        cyc();
        wb_valid = 1'b0; issue_valid = 1'b0;
        expect_v("r0_read_p0", S_RD0, 32'd0);
        expect_v("r0_outstanding", S_OUTS, 32'd0);
        expect_v("r0_no_wb_err", S_WERR, 32'd0);

        // Issue r8, then RAW busy, WAW stall, write-back release
        issue_valid = 1'b1; issue_addr = 5'd8;
        expect_v("r8_issue_ready", S_IRDY, 32'd1);
        cyc();
        rd_addr[9:5] = 5'd8;
        expect_v("r8_busy", S_BUSY1, 32'd1);
        expect_v("r8_outstanding", S_OUTS, 32'd1);
        expect_v("r8_reissue_blocked", S_IRDY, 32'd0);
        cyc();
        issue_valid = 1'b0;
        wb_valid = 1'b1; wb_addr = 5'd8; wb_data = 32'h55;
        expect_v("r8_wb_unbusy", S_BUSY1, 32'd0);
        expect_v("r8_wb_bypass", S_RD1, 32'h55);
        expect_v("r8_wb_issue_ready", S_IRDY, 32'd1);
        expect_v("r8_wb_outstanding_pre", S_OUTS, 32'd1);
        cyc();
        wb_valid = 1'b0;
        expect_v("r8_outstanding_post", S_OUTS, 32'd0);
        expect_v("r8_no_wb_err", S_WERR, 32'd0);
        expect_v("r8_stored", S_RD1, 32'h55);

        // Write-back to never-issued r9
        wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h99;
        cyc();
        wb_valid = 1'b0;
        rd_addr[4:0] = 5'd9;
        expect_v("r9_stored", S_RD0, 32'h99);
        expect_v("r9_wb_err", S_WERR, 32'd1);
        cyc();
        expect_v("r9_wb_err_one_cycle", S_WERR, 32'd0);

        // Same-cycle issue and write-back to pending r12: issue wins
        issue_valid = 1'b1; issue_addr = 5'd12;
        cyc();
        wb_valid = 1'b1; wb_addr = 5'd12; wb_data = 32'hC0DE;
        expect_v("r12_pending_count", S_OUTS, 32'd1);
        expect_v("r12_issue_ready_wb", S_IRDY, 32'd1);
        cyc();
        wb_valid = 1'b0; issue_valid = 1'b0;
        rd_addr[4:0] = 5'd12;
        expect_v("r12_data", S_RD0, 32'hC0DE);
        expect_v("r12_still_busy", S_BUSY0, 32'd1);
        expect_v("r12_outstanding", S_OUTS, 32'd1);
        expect_v("r12_no_wb_err", S_WERR, 32'd0);

        // Build three pending registers, then asynchronous reset mid-cycle
        issue_valid = 1'b1; issue_addr = 5'd3;
        cyc();
        issue_addr = 5'd4;
        cyc();
        issue_valid = 1'b0;
        expect_v("three_pending", S_OUTS, 32'd3);
        cyc();
        #1;
        rd_addr = {5'd5, 5'd12};
        wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'hAAAA;
        rst = 1'b1;
        #1;
        expect_v("async_rst_outstanding", S_OUTS, 32'd0);
        expect_v("async_rst_wb_err", S_WERR, 32'd0);
        expect_v("async_rst_r12", S_RD0, rst_val(12));
        expect_v("async_rst_r5", S_RD1, rst_val(5));
        expect_v("async_rst_busy", S_BUSY0, 32'd0);
        cyc();
        wb_valid = 1'b0;
        rst = 1'b0;
        rd_addr[4:0] = 5'd3;
        expect_v("lost_write_r3", S_RD0, rst_val(3));
        expect_v("post_rst_outstanding", S_OUTS, 32'd0);
        expect_v("post_rst_issue_ready", S_IRDY, 32'd1);

        @(negedge clk);
        #1;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d unchecked items expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
